ik_theta_update: RTL

- Downstream stage of the IK Jacobian/inverse top level. Consumes jacobian_matrix J (6 task rows x 6 joints) and inverse M = (J·J^T + bias)^-1, plus a 6-element task-space error e.
- Computes dtheta = J^T·(M·e) with one serial signed MAC, then applies a scaled, saturated update to the joint-angle register file.
- Raises a converged flag when every |dtheta| falls below a tolerance.

---
 rtl/ik_theta_update.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ik_theta_update.sv
// IK joint-angle update: dtheta = J^T (M e) on one serial MAC,
// then a gain-scaled, clamped write into the theta register file.
module ik_theta_update #(
  parameter int W          = 27,
  parameter int FRAC       = 16,
  parameter int ACC_W      = 33,
  parameter int STEP_SHIFT = 1,
  parameter int THETA_MAX  = 205887,
  parameter int THETA_MIN  = -205887,
  parameter int TOL        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              load_theta,
  input  logic [6*W-1:0]    theta_init,
  input  logic [36*W-1:0]   jacobian_matrix,
  input  logic [36*W-1:0]   inverse,
  input  logic [6*W-1:0]    error,
  output logic              busy,
  output logic              done,
  output logic [6*W-1:0]    theta,
  output logic [6*W-1:0]    dtheta,
  output logic              converged
);

  // Wide enough for six full-range shifted products, so no term ever wraps.
  localparam int PAW = 2*W - FRAC + 3;
  localparam int AW  = (ACC_W > PAW) ? ACC_W : PAW;

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W:0] TMAX = (W+1)'(THETA_MAX);
  localparam logic signed [W:0] TMIN = (W+1)'(THETA_MIN);
  localparam logic signed [W:0] TOLW = (W+1)'(TOL);

  typedef enum logic [2:0] {
    IDLE,
    CAP,
    CALC_Y,
    CALC_D,
    UPDATE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] jm_q [36];
  logic signed [W-1:0] mm_q [36];
  logic signed [W-1:0] e_q  [6];
  logic signed [W-1:0] y_q  [6];
  logic signed [W-1:0] d_q  [6];
  logic signed [W-1:0] th_q [6];
  logic signed [W-1:0] dt_q [6];
  logic signed [AW-1:0] acc_q;
  logic [2:0] i_q, k_q;
  logic conv_q;

  logic [5:0] idx;
  logic signed [W-1:0] op_a, op_b;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0] term, acc_nx;
  logic last_k, last_i;

  logic signed [W-1:0] upd_th [6];
  logic [5:0] cv;
  logic signed [W:0] dw, ds, sum, mag;

  function automatic logic signed [W-1:0] sat_w(
    input logic signed [AW-1:0] v
  );
    if (v > SMAX)      sat_w = SMAX[W-1:0];
    else if (v < SMIN) sat_w = SMIN[W-1:0];
    else               sat_w = v[W-1:0];
  endfunction

  assign last_k = (k_q == 3'd5);
  assign last_i = (i_q == 3'd5);

  // CALC_Y walks M row-major; CALC_D walks J column-major (J^T).
  always_comb begin
    idx  = '0;
    op_a = '0;
    op_b = '0;
    if (state_q == CALC_D) begin
      idx  = {3'd0, k_q} * 6'd6 + {3'd0, i_q};
      op_a = jm_q[idx];
      op_b = y_q[k_q];
    end else begin
      idx  = {3'd0, i_q} * 6'd6 + {3'd0, k_q};
      op_a = mm_q[idx];
      op_b = e_q[k_q];
    end
  end

  assign prod   = op_a * op_b;
  assign term   = AW'(prod >>> FRAC);
  assign acc_nx = acc_q + term;

  always_comb begin
    dw  = '0;
    ds  = '0;
    sum = '0;
    mag = '0;
    cv  = '0;
    for (int j = 0; j < 6; j++) begin
      dw  = {d_q[j][W-1], d_q[j]};
      ds  = dw >>> STEP_SHIFT;
      sum = {th_q[j][W-1], th_q[j]} + ds;
      if (sum > TMAX)      upd_th[j] = TMAX[W-1:0];
      else if (sum < TMIN) upd_th[j] = TMIN[W-1:0];
      else                 upd_th[j] = sum[W-1:0];
      mag   = dw[W] ? -dw : dw;
      cv[j] = (mag < TOLW);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !load_theta) state_d = CAP;
      CAP:     state_d = CALC_Y;
      CALC_Y:  if (last_i && last_k) state_d = CALC_D;
      CALC_D:  if (last_i && last_k) state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 36; n++) begin
        jm_q[n] <= '0;
        mm_q[n] <= '0;
      end
      for (int n = 0; n < 6; n++) begin
        e_q[n]  <= '0;
        y_q[n]  <= '0;
        d_q[n]  <= '0;
        th_q[n] <= '0;
        dt_q[n] <= '0;
      end
      acc_q  <= '0;
      i_q    <= '0;
      k_q    <= '0;
      conv_q <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (load_theta) begin
            for (int n = 0; n < 6; n++)
              th_q[n] <= theta_init[n*W +: W];
          end else if (start) begin
            for (int n = 0; n < 36; n++) begin
              jm_q[n] <= jacobian_matrix[n*W +: W];
              mm_q[n] <= inverse[n*W +: W];
            end
            for (int n = 0; n < 6; n++)
              e_q[n] <= error[n*W +: W];
          end
        end
        CAP: begin
          acc_q <= '0;
          i_q   <= '0;
          k_q   <= '0;
        end
        CALC_Y, CALC_D: begin
          if (last_k) begin
            acc_q <= '0;
            k_q   <= '0;
            i_q   <= last_i ? 3'd0 : i_q + 3'd1;
            if (state_q == CALC_Y) y_q[i_q] <= sat_w(acc_nx);
            else                   d_q[i_q] <= sat_w(acc_nx);
          end else begin
            acc_q <= acc_nx;
            k_q   <= k_q + 3'd1;
          end
        end
        UPDATE: begin
          for (int n = 0; n < 6; n++) begin
            th_q[n] <= upd_th[n];
            dt_q[n] <= d_q[n];
          end
          conv_q <= &cv;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign converged = conv_q;

  for (genvar g = 0; g < 6; g++) begin : g_out
    assign theta[g*W +: W]  = th_q[g];
    assign dtheta[g*W +: W] = dt_q[g];
  end

endmodule
